ipu_frame_sequencer: RTL and testbench

Frame-level controller placed between the camera capture stage and the IPU (color filter + group detection).
- Detects start/end of frame from the raw pixel counters and gates pixel-valid into the IPU, so exactly one whole frame is processed per cycle of operation.
- Applies a shadowed color threshold that changes only on frame boundaries.
- Waits for the IPU result with a timeout, tracks consecutive misses, and presents the tracked position to the host through a valid/ready handshake.

---
 rtl/ipu_pkg.sv | 16 +
 rtl/ipu_frame_sequencer.sv | 151 +++++++++++++++
 tb/tb_ipu_frame_sequencer.sv | 268 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/ipu_pkg.sv
// Shared definitions for the IPU frame-level control path.
package ipu_pkg;

  localparam int unsigned COORD_W = 11;
  localparam int unsigned THR_W   = 12;
  localparam logic [THR_W-1:0] THR_DEFAULT = 12'd2048;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_SOF,
    ACTIVE,
    WAIT_RESULT,
    REPORT
  } ipu_state_e;

endpackage

// File: rtl/ipu_frame_sequencer.sv
// Frame sequencer between capture and IPU: gates one whole frame at a time,
// shadows the colour threshold, waits for the IPU result and reports it to the host.
module ipu_frame_sequencer
  import ipu_pkg::*;
#(
  parameter int unsigned FRAME_W        = 640,
  parameter int unsigned FRAME_H        = 480,
  parameter int unsigned RESULT_TIMEOUT = 1024,
  parameter int unsigned MISS_LIMIT     = 4
) (
  input  logic               iCLK,
  input  logic               iRST,
  input  logic               iEnable,
  input  logic               iDVAL,
  input  logic [COORD_W-1:0] iX_Cont,
  input  logic [COORD_W-1:0] iY_Cont,
  output logic               oIPU_DVAL,
  output logic               oFrame_start,
  input  logic               iCfg_wr,
  input  logic [THR_W-1:0]   iCfg_thr,
  output logic [THR_W-1:0]   oThr,
  input  logic               iGD_DVAL,
  input  logic [COORD_W-1:0] iGD_X,
  input  logic [COORD_W-1:0] iGD_Y,
  output logic               oPos_valid,
  input  logic               iPos_ready,
  output logic [COORD_W-1:0] oPos_X,
  output logic [COORD_W-1:0] oPos_Y,
  output logic               oLost,
  output logic [15:0]        oFrame_cnt
);

  localparam int unsigned TMR_W  = $clog2(RESULT_TIMEOUT + 1);
  localparam int unsigned MISS_W = $clog2(MISS_LIMIT + 1);
  localparam logic [COORD_W-1:0] X_LAST   = COORD_W'(FRAME_W - 1);
  localparam logic [COORD_W-1:0] Y_LAST   = COORD_W'(FRAME_H - 1);
  localparam logic [TMR_W-1:0]   TMR_LAST = TMR_W'(RESULT_TIMEOUT - 1);
  localparam logic [MISS_W-1:0]  MISS_MAX = MISS_W'(MISS_LIMIT);

  ipu_state_e          state_q;
  logic [TMR_W-1:0]    timer_q;
  logic [MISS_W-1:0]   miss_q;
  logic [MISS_W-1:0]   miss_d;
  logic                have_result_q;
  logic [THR_W-1:0]    pending_q;
  logic [THR_W-1:0]    thr_q;
  logic [COORD_W-1:0]  pos_x_q;
  logic [COORD_W-1:0]  pos_y_q;
  logic                pos_valid_q;
  logic                lost_q;
  logic                frame_start_q;
  logic [15:0]         frame_cnt_q;
  logic [15:0]         frame_cnt_d;

  logic sof;
  logic eof;
  logic sof_accept;
  logic gd_capture;

  // A SOF seen while iEnable is low is neither accepted nor passed to the IPU.
  always_comb begin
    sof         = iDVAL && (iX_Cont == '0) && (iY_Cont == '0);
    eof         = iDVAL && (iX_Cont == X_LAST) && (iY_Cont == Y_LAST);
    sof_accept  = (state_q == WAIT_SOF) && iEnable && sof;
    gd_capture  = iGD_DVAL && ((state_q == ACTIVE) || (state_q == WAIT_RESULT));
    miss_d      = (miss_q >= MISS_MAX) ? MISS_MAX : miss_q + MISS_W'(1);
    frame_cnt_d = frame_cnt_q + (sof_accept ? 16'd1 : 16'd0);
  end

  assign oIPU_DVAL = iDVAL && ((state_q == ACTIVE) || sof_accept);

  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      state_q       <= IDLE;
      timer_q       <= '0;
      miss_q        <= '0;
      have_result_q <= 1'b0;
      pending_q     <= THR_DEFAULT;
      thr_q         <= THR_DEFAULT;
      pos_x_q       <= '0;
      pos_y_q       <= '0;
      pos_valid_q   <= 1'b0;
      lost_q        <= 1'b0;
      frame_start_q <= 1'b0;
      frame_cnt_q   <= '0;
    end else begin
      frame_start_q <= 1'b0;
      frame_cnt_q   <= frame_cnt_d;

      if (iCfg_wr) pending_q <= iCfg_thr;

      // Last result of the frame wins; results outside the frame window are dropped.
      if (gd_capture) begin
        pos_x_q       <= iGD_X;
        pos_y_q       <= iGD_Y;
        have_result_q <= 1'b1;
      end

      case (state_q)
        IDLE: begin
          if (iEnable) state_q <= WAIT_SOF;
        end
        WAIT_SOF: begin
          if (!iEnable) begin
            state_q <= IDLE;
          end else if (sof) begin
            thr_q         <= iCfg_wr ? iCfg_thr : pending_q;
            frame_start_q <= 1'b1;
            have_result_q <= 1'b0;
            state_q       <= ACTIVE;
          end
        end
        ACTIVE: begin
          if (eof) begin
            timer_q <= '0;
            state_q <= WAIT_RESULT;
          end
        end
        WAIT_RESULT: begin
          timer_q <= timer_q + TMR_W'(1);
          if (have_result_q || iGD_DVAL) begin
            miss_q      <= '0;
            lost_q      <= 1'b0;
            pos_valid_q <= 1'b1;
            state_q     <= REPORT;
          end else if (timer_q == TMR_LAST) begin
            miss_q <= miss_d;
            if (miss_d >= MISS_MAX) lost_q <= 1'b1;
            state_q <= WAIT_SOF;
          end
        end
        REPORT: begin
          if (iPos_ready) begin
            pos_valid_q <= 1'b0;
            state_q     <= iEnable ? WAIT_SOF : IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign oFrame_start = frame_start_q;
  assign oThr         = thr_q;
  assign oPos_valid   = pos_valid_q;
  assign oPos_X       = pos_x_q;
  assign oPos_Y       = pos_y_q;
  assign oLost        = lost_q;
  assign oFrame_cnt   = frame_cnt_q;

endmodule

// File: tb/tb_ipu_frame_sequencer.sv
// Directed bench for ipu_frame_sequencer with a position scoreboard.
module tb_ipu_frame_sequencer;
  import ipu_pkg::*;

  localparam int FW = 8;
  localparam int FH = 4;

  logic               iCLK = 1'b0;
  logic               iRST;
  logic               iEnable;
  logic               iDVAL;
  logic [COORD_W-1:0] iX_Cont;
  logic [COORD_W-1:0] iY_Cont;
  logic               oIPU_DVAL;
  logic               oFrame_start;
  logic               iCfg_wr;
  logic [THR_W-1:0]   iCfg_thr;
  logic [THR_W-1:0]   oThr;
  logic               iGD_DVAL;
  logic [COORD_W-1:0] iGD_X;
  logic [COORD_W-1:0] iGD_Y;
  logic               oPos_valid;
  logic               iPos_ready;
  logic [COORD_W-1:0] oPos_X;
  logic [COORD_W-1:0] oPos_Y;
  logic               oLost;
  logic [15:0]        oFrame_cnt;

  int tests = 0;
  int fails = 0;
  int gated = 0;
  int fs_cnt = 0;
  int g0;
  int f0;
  logic [2*COORD_W-1:0] exp_q[$];
  logic [2*COORD_W-1:0] sb_e;

  ipu_frame_sequencer #(
    .FRAME_W(8),
    .FRAME_H(4),
    .RESULT_TIMEOUT(16),
    .MISS_LIMIT(2)
  ) dut (
    .iCLK(iCLK), .iRST(iRST), .iEnable(iEnable), .iDVAL(iDVAL),
    .iX_Cont(iX_Cont), .iY_Cont(iY_Cont), .oIPU_DVAL(oIPU_DVAL),
    .oFrame_start(oFrame_start), .iCfg_wr(iCfg_wr), .iCfg_thr(iCfg_thr),
    .oThr(oThr), .iGD_DVAL(iGD_DVAL), .iGD_X(iGD_X), .iGD_Y(iGD_Y),
    .oPos_valid(oPos_valid), .iPos_ready(iPos_ready), .oPos_X(oPos_X),
    .oPos_Y(oPos_Y), .oLost(oLost), .oFrame_cnt(oFrame_cnt)
  );

  always #5 iCLK = ~iCLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Pixel/pulse counters and scoreboard pop on every host handshake.
  always @(negedge iCLK) begin
    if (oIPU_DVAL) gated++;
    if (oFrame_start) fs_cnt++;
    if (iRST && oPos_valid && iPos_ready) begin
      check("sb_pending", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        sb_e = exp_q.pop_front();
        check("sb_pos_x", 32'(oPos_X), 32'(sb_e[2*COORD_W-1:COORD_W]));
        check("sb_pos_y", 32'(oPos_Y), 32'(sb_e[COORD_W-1:0]));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge iCLK);
    #1;
  endtask

  task automatic pix(input int i);
    iDVAL   = 1'b1;
    iX_Cont = COORD_W'(i % FW);
    iY_Cont = COORD_W'(i / FW);
    tick();
  endtask

  task automatic run_frame(input int gd_at, input logic [COORD_W-1:0] gx,
                           input logic [COORD_W-1:0] gy, input bit push,
                           input int cfg_at, input logic [THR_W-1:0] cfg,
                           input int dis_at);
    for (int i = 0; i < FW * FH; i++) begin
      iDVAL    = 1'b1;
      iX_Cont  = COORD_W'(i % FW);
      iY_Cont  = COORD_W'(i / FW);
      iGD_DVAL = (i == gd_at);
      iGD_X    = gx;
      iGD_Y    = gy;
      if (i == gd_at && push) exp_q.push_back({gx, gy});
      iCfg_wr  = (i == cfg_at);
      iCfg_thr = cfg;
      if (i == dis_at) iEnable = 1'b0;
      tick();
    end
    iDVAL    = 1'b0;
    iGD_DVAL = 1'b0;
    iCfg_wr  = 1'b0;
  endtask

  task automatic wait_valid(input string tag);
    int n = 0;
    while (!oPos_valid && n < 64) begin
      tick();
      n++;
    end
    check(tag, 32'(oPos_valid), 32'd1);
  endtask

  initial begin
    iRST = 1'b0; iEnable = 1'b0; iDVAL = 1'b0; iX_Cont = '0; iY_Cont = '0;
    iCfg_wr = 1'b0; iCfg_thr = '0; iGD_DVAL = 1'b0; iGD_X = '0; iGD_Y = '0;
    iPos_ready = 1'b0;
    repeat (3) tick();
    check("rst_ipu_dval", 32'(oIPU_DVAL), 32'd0);
    check("rst_frame_start", 32'(oFrame_start), 32'd0);
    check("rst_pos_valid", 32'(oPos_valid), 32'd0);
    check("rst_pos_x", 32'(oPos_X), 32'd0);
    check("rst_pos_y", 32'(oPos_Y), 32'd0);
    check("rst_lost", 32'(oLost), 32'd0);
    check("rst_frame_cnt", 32'(oFrame_cnt), 32'd0);
    check("rst_thr", 32'(oThr), 32'h800);
    iRST = 1'b1;
    tick();

    // 1: enable mid-frame, then one whole gated frame
    iEnable = 1'b1;
    tick();
    g0 = gated;
    for (int i = 11; i < FW * FH; i++) pix(i);
    iDVAL = 1'b0;
    check("midframe_ungated", 32'(gated - g0), 32'd0);
    g0 = gated; f0 = fs_cnt;
    run_frame(20, 11'd5, 11'd2, 1'b1, -1, 12'h000, -1);
    check("f1_gated", 32'(gated - g0), 32'd32);
    check("f1_fs_pulses", 32'(fs_cnt - f0), 32'd1);
    check("f1_frame_cnt", 32'(oFrame_cnt), 32'd1);

    // 2: report held while host not ready; frames in REPORT are skipped
    wait_valid("f1_valid");
    check("f1_pos_x", 32'(oPos_X), 32'd5);
    check("f1_pos_y", 32'(oPos_Y), 32'd2);
    g0 = gated; f0 = fs_cnt;
    run_frame(6, 11'd9, 11'd9, 1'b0, -1, 12'h000, -1);
    check("skip_gated", 32'(gated - g0), 32'd0);
    check("skip_fs", 32'(fs_cnt - f0), 32'd0);
    check("hold_valid", 32'(oPos_valid), 32'd1);
    check("hold_pos_x", 32'(oPos_X), 32'd5);
    check("hold_pos_y", 32'(oPos_Y), 32'd2);
    check("skip_frame_cnt", 32'(oFrame_cnt), 32'd1);
    iPos_ready = 1'b1;
    tick();
    check("valid_drop", 32'(oPos_valid), 32'd0);

    // 3: two timeouts raise oLost, a result clears it
    run_frame(-1, 11'd0, 11'd0, 1'b0, -1, 12'h000, -1);
    repeat (15) tick();
    check("to_a_lost", 32'(oLost), 32'd0);
    tick();
    g0 = gated;
    run_frame(-1, 11'd0, 11'd0, 1'b0, -1, 12'h000, -1);
    check("to_b_gated", 32'(gated - g0), 32'd32);
    repeat (15) tick();
    check("to_b_lost_early", 32'(oLost), 32'd0);
    tick();
    check("to_b_lost", 32'(oLost), 32'd1);
    run_frame(9, 11'd100, 11'd50, 1'b1, -1, 12'h000, -1);
    wait_valid("fc_valid");
    check("lost_clear", 32'(oLost), 32'd0);
    check("fc_frame_cnt", 32'(oFrame_cnt), 32'd4);
    tick();

    // 4: threshold shadowing and SOF bypass; result arriving in WAIT_RESULT
    run_frame(-1, 11'd0, 11'd0, 1'b0, 10, 12'h123, -1);
    tick();
    tick();
    iGD_DVAL = 1'b1; iGD_X = 11'd7; iGD_Y = 11'd1;
    exp_q.push_back({11'd7, 11'd1});
    tick();
    iGD_DVAL = 1'b0;
    wait_valid("fd_valid");
    check("thr_unchanged", 32'(oThr), 32'h800);
    tick();
    run_frame(3, 11'd20, 11'd30, 1'b1, -1, 12'h000, -1);
    wait_valid("fe_valid");
    check("thr_pending", 32'(oThr), 32'h123);
    tick();
    run_frame(4, 11'd1, 11'd2, 1'b1, 0, 12'h456, -1);
    wait_valid("ff_valid");
    check("thr_bypass", 32'(oThr), 32'h456);
    tick();

    // 5: disable mid-frame completes and reports, then IDLE; reset mid-frame
    run_frame(12, 11'd33, 11'd44, 1'b1, -1, 12'h000, 10);
    wait_valid("fg_valid");
    tick();
    check("fg_valid_drop", 32'(oPos_valid), 32'd0);
    g0 = gated;
    run_frame(-1, 11'd0, 11'd0, 1'b0, -1, 12'h000, -1);
    check("idle_gated", 32'(gated - g0), 32'd0);
    check("idle_frame_cnt", 32'(oFrame_cnt), 32'd8);
    iEnable = 1'b1;
    tick();
    g0 = gated;
    for (int i = 0; i < 16; i++) pix(i);
    check("fi_partial_gated", 32'(gated - g0), 32'd16);
    iDVAL = 1'b1; iX_Cont = 11'd0; iY_Cont = 11'd2;
    iRST = 1'b0;
    #1;
    check("mrst_ipu_dval", 32'(oIPU_DVAL), 32'd0);
    check("mrst_frame_start", 32'(oFrame_start), 32'd0);
    check("mrst_pos_valid", 32'(oPos_valid), 32'd0);
    check("mrst_pos_x", 32'(oPos_X), 32'd0);
    check("mrst_pos_y", 32'(oPos_Y), 32'd0);
    check("mrst_lost", 32'(oLost), 32'd0);
    check("mrst_frame_cnt", 32'(oFrame_cnt), 32'd0);
    check("mrst_thr", 32'(oThr), 32'h800);
    tick();
    iRST = 1'b1;
    g0 = gated;
    for (int i = 17; i < FW * FH; i++) pix(i);
    iDVAL = 1'b0;
    check("post_rst_ungated", 32'(gated - g0), 32'd0);
    g0 = gated; f0 = fs_cnt;
    run_frame(7, 11'd2, 11'd3, 1'b1, -1, 12'h000, -1);
    check("fj_gated", 32'(gated - g0), 32'd32);
    check("fj_fs", 32'(fs_cnt - f0), 32'd1);
    check("fj_frame_cnt", 32'(oFrame_cnt), 32'd1);
    check("fj_thr_default", 32'(oThr), 32'h800);
    wait_valid("fj_valid");
    tick();

    // 6: frame counter wrap from a preloaded value
    force dut.frame_cnt_q = 16'hFFFF;
    tick();
    tick();
    release dut.frame_cnt_q;
    run_frame(5, 11'd4, 11'd4, 1'b1, -1, 12'h000, -1);
    wait_valid("fk_valid");
    check("wrap_cnt0", 32'(oFrame_cnt), 32'h0000);
    tick();
    run_frame(8, 11'd6, 11'd1, 1'b1, -1, 12'h000, -1);
    wait_valid("fl_valid");
    check("wrap_cnt1", 32'(oFrame_cnt), 32'h0001);
    tick();
    tick();

    check("sb_empty", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
